// File: rtl/obi_axil_master_bridge.sv
// ---------------------------------------------------------------------------
// obi_axil_master_bridge
//
// Turns the CV32E40P OBI data interface (req/gnt/rvalid) into an AXI4-Lite
// master. One transaction is in flight at a time. Every granted OBI request
// produces exactly one obi_rvalid_o pulse. An optional watchdog turns a hung
// slave into a bus error, so the core is not stalled forever.
//
// Ports:
//   clk, rst_n                 clock (rising edge); asynchronous active-low reset
//   obi_req_i / obi_gnt_o      request and combinational grant
//   obi_addr_i, obi_we_i,      request attributes, captured on grant
//   obi_be_i, obi_wdata_i
//   obi_rvalid_o, obi_rdata_o, registered response: single-cycle pulse, with
//   obi_err_o                  data and error held until the next pulse
//   m_aw*, m_w*, m_b*          AXI-Lite write address, write data and write
//                              response channels
//   m_ar*, m_r*                AXI-Lite read address and read data channels
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in WAIT_B/WAIT_R before an abort with an
//                   error; 0 removes the watchdog
//   CNT_W           width of the watchdog counter
// ---------------------------------------------------------------------------
module obi_axil_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WAIT_B  = 3'd2,
        RD_ADDR = 3'd3,
        WAIT_R  = 3'd4
    } state_t;

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        aw_done_reg;
    logic        w_done_reg;
    logic        timeout;

    // The AW and W handshakes may complete in either order. "All" folds in a
    // handshake that completes in the current cycle.
    logic aw_all;
    logic w_all;

    // The valids and readies are decoded from the state register. The state
    // register is reset asynchronously, so the valids drop as soon as rst_n
    // goes low.
    assign obi_gnt_o = obi_req_i & (state_reg == IDLE);
    assign m_awaddr  = addr_reg;
    assign m_araddr  = addr_reg;
    assign m_wdata   = wdata_reg;
    assign m_wstrb   = be_reg;
    assign m_awvalid = (state_reg == WR_ADDR) & ~aw_done_reg;
    assign m_wvalid  = (state_reg == WR_ADDR) & ~w_done_reg;
    assign m_arvalid = (state_reg == RD_ADDR);
    assign m_bready  = (state_reg == WAIT_B);
    assign m_rready  = (state_reg == WAIT_R);

    assign aw_all = aw_done_reg | (m_awvalid & m_awready);
    assign w_all  = w_done_reg  | (m_wvalid  & m_wready);

    // Watchdog. The counter holds 0 outside the wait states, so it is already
    // clear when a wait state is entered. It holds k during the (k+1)-th wait
    // cycle. When it holds TIMEOUT_CYCLES-1, that cycle is the last one
    // allowed. A response in that cycle still completes normally, because the
    // response is tested before the timeout in the FSM below.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
            logic [CNT_W-1:0] cnt_reg;
            logic             in_wait;

            assign in_wait = (state_reg == WAIT_B) | (state_reg == WAIT_R);
            assign timeout = in_wait & (cnt_reg == LAST_CNT);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (!in_wait) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            be_reg       <= '0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            obi_rvalid_o <= 1'b0;
            obi_rdata_o  <= '0;
            obi_err_o    <= 1'b0;
        end else begin
            obi_rvalid_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (obi_req_i) begin
                        addr_reg  <= obi_addr_i;
                        wdata_reg <= obi_wdata_i;
                        be_reg    <= obi_be_i;
                        state_reg <= obi_we_i ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (aw_all && w_all) begin
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        state_reg   <= WAIT_B;
                    end else begin
                        aw_done_reg <= aw_all;
                        w_done_reg  <= w_all;
                    end
                end
                WAIT_B: begin
                    if (m_bvalid) begin
                        obi_rvalid_o <= 1'b1;
                        obi_rdata_o  <= '0;
                        obi_err_o    <= m_bresp[1];
                        state_reg    <= IDLE;
                    end else if (timeout) begin
                        obi_rvalid_o <= 1'b1;
                        obi_rdata_o  <= '0;
                        obi_err_o    <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (m_arready) begin
                        state_reg <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (m_rvalid) begin
                        obi_rvalid_o <= 1'b1;
                        obi_rdata_o  <= m_rdata;
                        obi_err_o    <= m_rresp[1];
                        state_reg    <= IDLE;
                    end else if (timeout) begin
                        obi_rvalid_o <= 1'b1;
                        obi_rdata_o  <= '0;
                        obi_err_o    <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obi_axil_master_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for obi_axil_master_bridge, with the watchdog enabled
// (TIMEOUT_CYCLES = 8).
//
// The bench plays both the OBI core and the AXI-Lite slave from one initial
// block. It drives inputs and samples outputs around the falling clock edge.
// The reference model holds the transaction-level rules: the set of valids
// and readies expected in each phase, the number of cycles each phase lasts
// given the slave delays, and the response data and error that follow.
// ---------------------------------------------------------------------------
module tb_obi_axil_master_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        obi_req_i = 1'b0;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i = '0;
    logic        obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = '0;
    logic [31:0] obi_wdata_i = '0;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready = 1'b0;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready = 1'b0;
    logic [1:0]  m_bresp = '0;
    logic        m_bvalid = 1'b0;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    obi_axil_master_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
        .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
        .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one OBI transaction end to end.
    // a_dly: cycles before awready (writes) or arready (reads).
    // w_dly: cycles before wready.
    // r_dly: wait cycles before the B/R response. A value of TO or more means
    //        the slave never answers.
    // b2b:   the request is presented in the response cycle of the previous
    //        transaction.
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int a_dly, input int w_dly,
                           input int r_dly, input logic [31:0] sdata, input logic [1:0] resp,
                           input bit b2b);
        int          cyc;
        int          k;
        bit          a_ok;
        bit          w_ok;
        bit          timed_out;
        logic [31:0] exp_rdata;
        logic        exp_err;

        if (!b2b) begin
            @(negedge clk);
            #1;
            chk("rvalid_single_pulse", obi_rvalid_o, 0);
            chk("rdata_hold", obi_rdata_o, last_rdata);
            chk("err_hold", obi_err_o, last_err);
        end
        obi_req_i   = 1'b1;
        obi_we_i    = we;
        obi_addr_i  = addr;
        obi_be_i    = be;
        obi_wdata_i = wdata;
        #1;
        chk("gnt_idle", obi_gnt_o, 1);

        // While the transaction is busy, keep presenting a new request with
        // changed attributes. It must not be granted, and it must not disturb
        // the captured attributes.
        @(negedge clk);
        obi_addr_i  = $urandom;
        obi_wdata_i = $urandom;
        obi_be_i    = 4'($urandom);
        obi_we_i    = 1'($urandom);

        if (we) begin
            cyc  = 0;
            a_ok = 1'b0;
            w_ok = 1'b0;
            while (!(a_ok && w_ok)) begin
                m_awready = (cyc >= a_dly);
                m_wready  = (cyc >= w_dly);
                m_bvalid  = 1'($urandom);
                m_bresp   = 2'b10;
                #1;
                chk("awvalid", m_awvalid, !a_ok);
                chk("wvalid", m_wvalid, !w_ok);
                chk("awaddr", m_awaddr, addr);
                chk("wdata", m_wdata, wdata);
                chk("wstrb", m_wstrb, be);
                chk("bready_wr_addr", m_bready, 0);
                chk("arvalid_wr", m_arvalid, 0);
                chk("gnt_busy", obi_gnt_o, 0);
                chk("rvalid_busy", obi_rvalid_o, 0);
                if (m_awready) a_ok = 1'b1;
                if (m_wready)  w_ok = 1'b1;
                @(negedge clk);
                cyc++;
            end
            m_awready = 1'b0;
            m_wready  = 1'b0;
        end else begin
            cyc = 0;
            forever begin
                m_arready = (cyc >= a_dly);
                #1;
                chk("arvalid", m_arvalid, 1);
                chk("araddr", m_araddr, addr);
                chk("rready_rd_addr", m_rready, 0);
                chk("awvalid_rd", m_awvalid, 0);
                chk("gnt_busy", obi_gnt_o, 0);
                chk("rvalid_busy", obi_rvalid_o, 0);
                if (m_arready) break;
                @(negedge clk);
                cyc++;
            end
            @(negedge clk);
            m_arready = 1'b0;
        end

        // Response wait: the slave answers after r_dly cycles, unless r_dly
        // is TO or more. In that case the watchdog ends the wait after TO
        // cycles.
        k         = 0;
        timed_out = 1'b0;
        forever begin
            if (we) begin
                m_bvalid = (k == r_dly);
                m_bresp  = (k == r_dly) ? resp : 2'($urandom);
            end else begin
                m_rvalid = (k == r_dly);
                m_rresp  = (k == r_dly) ? resp : 2'($urandom);
                m_rdata  = (k == r_dly) ? sdata : $urandom;
            end
            #1;
            chk(we ? "bready_wait" : "rready_wait", we ? m_bready : m_rready, 1);
            chk("other_ready_wait", we ? m_rready : m_bready, 0);
            chk("valids_wait", {m_awvalid, m_wvalid, m_arvalid}, 0);
            chk("gnt_busy", obi_gnt_o, 0);
            chk("rvalid_busy", obi_rvalid_o, 0);
            if (k == r_dly) break;
            if (k == TO - 1) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            k++;
        end

        @(negedge clk);
        m_bvalid  = 1'b0;
        m_rvalid  = 1'b0;
        obi_req_i = 1'b0;
        exp_rdata = (timed_out || we) ? 32'h0 : sdata;
        exp_err   = timed_out ? 1'b1 : resp[1];
        #1;
        chk("obi_rvalid", obi_rvalid_o, 1);
        chk("obi_rdata", obi_rdata_o, exp_rdata);
        chk("obi_err", obi_err_o, exp_err);
        chk("readies_after", {m_bready, m_rready}, 0);
        $display("txn we=%0d addr=%h be=%b a_dly=%0d w_dly=%0d r_dly=%0d b2b=%0d timeout=%0d rdata=%h err=%0d",
                 we, addr, be, a_dly, w_dly, r_dly, b2b, timed_out, obi_rdata_o, obi_err_o);
        last_rdata = exp_rdata;
        last_err   = exp_err;
    endtask

    initial begin
        bit b2b_next;

        // Values while reset is asserted
        #3;
        chk("rst_rvalid", obi_rvalid_o, 0);
        chk("rst_rdata", obi_rdata_o, 0);
        chk("rst_err", obi_err_o, 0);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        chk("rst_addr", m_awaddr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_wstrb", m_wstrb, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: the basic write, a write with delayed AW, reads with
        // OKAY and SLVERR, back-to-back, a hung slave, and a response on the
        // last allowed cycle.
        run_txn(1'b1, 32'h0000_0010, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 32'h0, 2'b00, 1'b0);
        run_txn(1'b1, 32'h0000_0014, 4'b0100, 32'hCAFE_F00D, 3, 0, 0, 32'h0, 2'b00, 1'b0);
        run_txn(1'b0, 32'h0000_0020, 4'b1111, 32'h0, 0, 0, 5, 32'h12345678, 2'b00, 1'b0);
        run_txn(1'b0, 32'h0000_0024, 4'b1111, 32'h0, 1, 0, 2, 32'hA5A5_0001, 2'b10, 1'b0);
        run_txn(1'b1, 32'h0000_0030, 4'b0011, 32'h0BAD_CAFE, 0, 2, 1, 32'h0, 2'b11, 1'b0);
        run_txn(1'b0, 32'h0000_0034, 4'b1111, 32'h0, 0, 0, 0, 32'h5566_7788, 2'b00, 1'b1);
        run_txn(1'b0, 32'h0000_0040, 4'b1111, 32'h0, 2, 0, 1000, 32'hFFFF_FFFF, 2'b00, 1'b0);
        run_txn(1'b1, 32'h0000_0044, 4'b1000, 32'h1111_2222, 0, 0, 1000, 32'h0, 2'b00, 1'b0);
        run_txn(1'b0, 32'h0000_0048, 4'b1111, 32'h0, 0, 0, TO - 1, 32'h7777_0007, 2'b00, 1'b0);

        // Reset asserted in WR_ADDR with AW still pending
        @(negedge clk);
        obi_req_i   = 1'b1;
        obi_we_i    = 1'b1;
        obi_addr_i  = 32'h0000_0050;
        obi_be_i    = 4'hF;
        obi_wdata_i = 32'h0;
        @(negedge clk);
        obi_req_i = 1'b0;
        #1;
        chk("pre_rst_awvalid", m_awvalid, 1);
        chk("pre_rst_wvalid", m_wvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_awvalid", m_awvalid, 0);
        chk("async_rst_wvalid", m_wvalid, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_no_rvalid", obi_rvalid_o, 0);
        end
        rst_n      = 1'b1;
        last_rdata = 32'h0;
        last_err   = 1'b0;

        // Randomised transactions against the same model
        b2b_next = 1'b0;
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), {$urandom_range(0, 255), 2'b00}, 4'($urandom), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9),
                    $urandom, 2'($urandom), b2b_next);
            b2b_next = 1'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
